// File: rtl/rv32i_pkg.sv
// RV32I decode package: opcode constants, ALU operation enum, result-source
// encodings, the ID/EX register layout and immediate/ALU decode helpers.
package rv32i_pkg;

    localparam int WORD_W = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } aluOp_t;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } immFmt_t;

    // Everything carried across the ID/EX boundary; all-zero is a bubble.
    typedef struct packed {
        logic              regWrite;
        logic              memWrite;
        logic              load;
        logic [1:0]        resultSrc;
        aluOp_t            aluCtrl;
        logic              aluSrc;
        logic              branch;
        logic              jal;
        logic              jalr;
        logic [2:0]        funct3;
        logic [WORD_W-1:0] rd1;
        logic [WORD_W-1:0] rd2;
        logic [WORD_W-1:0] immExt;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pcPlus4;
    } idEx_t;

    // Immediate generation; every format sign-extends from instr[31].
    function automatic logic signed [WORD_W-1:0] immGen(input logic [31:0] instr,
                                                        input immFmt_t fmt);
        logic signed [WORD_W-1:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // ALU op for R and I-ALU forms; only register forms may select SUB.
    function automatic aluOp_t aluDecode(input logic [2:0] funct3, input logic bit30,
                                         input logic isReg);
        aluOp_t op;
        case (funct3)
            3'b000:  op = (isReg && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle between IF/ID, writeback and the decode stage, plus the ID/EX
// outputs. The slave modport is the decode stage's view.
interface decode_stage_if;
    import rv32i_pkg::*;

    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        flush_e;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;

    logic        load_use_d;
    logic        jal_d;
    logic        jalr_d;
    logic        reg_write_e;
    logic        mem_write_e;
    logic        load_e;
    logic [1:0]  result_src_e;
    aluOp_t      alu_ctrl_e;
    logic        alu_src_e;
    logic        branch_e;
    logic        jal_e;
    logic        jalr_e;
    logic [2:0]  funct3_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [31:0] imm_ext_e;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    logic [31:0] pc_e;
    logic [31:0] pc_plus4_e;

    modport master (
        output instr_d, pc_d, pc_plus4_d, flush_e, reg_write_w, rd_w, result_w,
        input  load_use_d, jal_d, jalr_d, reg_write_e, mem_write_e, load_e,
               result_src_e, alu_ctrl_e, alu_src_e, branch_e, jal_e, jalr_e,
               funct3_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e
    );

    modport slave (
        input  instr_d, pc_d, pc_plus4_d, flush_e, reg_write_w, rd_w, result_w,
        output load_use_d, jal_d, jalr_d, reg_write_e, mem_write_e, load_e,
               result_src_e, alu_ctrl_e, alu_src_e, branch_e, jal_e, jalr_e,
               funct3_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e
    );

endinterface

// File: rtl/decode_stage_register_file.sv
// 2-read 1-write register file, asynchronous read, x0 reads as zero.
// Optional macro WB_BYPASS_EN: a read of the register being written this
// cycle returns the incoming write data instead of the stored value.
module register_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREGS];
    logic            hit1;
    logic            hit2;

`ifdef WB_BYPASS_EN
    assign hit1 = we && (wa == rs1);
    assign hit2 = we && (wa == rs2);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    // Storage: cleared on reset, x0 never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // Read ports: x0 forced to zero, optional same-cycle writeback bypass.
    always_comb begin
        rd1 = (rs1 == '0) ? '0 : (hit1 ? wd : regs[rs1]);
        rd2 = (rs2 == '0) ? '0 : (hit2 ? wd : regs[rs2]);
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decodes the IF/ID instruction, builds the immediate, reads
// the register file and registers the result into ID/EX. A load in EX whose
// destination feeds this instruction stalls fetch and inserts a bubble.
// Optional macro WB_BYPASS_EN (in register_file) enables WB->ID read bypass.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rfRd1;
    logic [31:0] rfRd2;
    idEx_t       dec;
    idEx_t       idEx_p1;
    immFmt_t     fmt;
    logic        legal;
    logic        readsRs2;
    logic        loadUse;

    assign instr  = bus.instr_d;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_regFile (
        .clk (clk),
        .rst (rst),
        .rs1 (rs1),
        .rs2 (rs2),
        .rd1 (rfRd1),
        .rd2 (rfRd2),
        .we  (bus.reg_write_w),
        .wa  (bus.rd_w),
        .wd  (bus.result_w)
    );

    // Decode: unknown opcodes (including all-zero) fall out as a full bubble.
    always_comb begin
        dec      = '0;
        fmt      = FMT_NONE;
        legal    = 1'b1;
        readsRs2 = 1'b0;
        case (opcode)
            OP_R: begin
                dec.regWrite = 1'b1;
                dec.aluCtrl  = aluDecode(funct3, instr[30], 1'b1);
                readsRs2     = 1'b1;
            end
            OP_IMM: begin
                dec.regWrite = 1'b1;
                dec.aluSrc   = 1'b1;
                dec.aluCtrl  = aluDecode(funct3, instr[30], 1'b0);
                fmt          = FMT_I;
            end
            OP_LOAD: begin
                dec.regWrite  = 1'b1;
                dec.load      = 1'b1;
                dec.resultSrc = RES_MEM;
                dec.aluSrc    = 1'b1;
                fmt           = FMT_I;
            end
            OP_STORE: begin
                dec.memWrite = 1'b1;
                dec.aluSrc   = 1'b1;
                fmt          = FMT_S;
                readsRs2     = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch  = 1'b1;
                dec.aluCtrl = ALU_SUB;
                fmt         = FMT_B;
                readsRs2    = 1'b1;
            end
            OP_JAL: begin
                dec.regWrite  = 1'b1;
                dec.jal       = 1'b1;
                dec.resultSrc = RES_PC4;
                fmt           = FMT_J;
            end
            OP_JALR: begin
                dec.regWrite  = 1'b1;
                dec.jalr      = 1'b1;
                dec.resultSrc = RES_PC4;
                dec.aluSrc    = 1'b1;
                fmt           = FMT_I;
            end
            OP_LUI: begin
                dec.regWrite = 1'b1;
                dec.aluSrc   = 1'b1;
                dec.aluCtrl  = ALU_PASSB;
                fmt          = FMT_U;
            end
            OP_AUIPC: begin
                dec.regWrite = 1'b1;
                dec.aluSrc   = 1'b1;
                fmt          = FMT_U;
            end
            default: legal = 1'b0;
        endcase
        if (legal) begin
            dec.funct3  = funct3;
            dec.rs1     = rs1;
            dec.rs2     = rs2;
            dec.rd      = dec.regWrite ? instr[11:7] : 5'd0;
            dec.rd1     = rfRd1;
            dec.rd2     = rfRd2;
            dec.immExt  = immGen(instr, fmt);
            dec.pc      = bus.pc_d;
            dec.pcPlus4 = bus.pc_plus4_d;
        end
    end

    assign loadUse = idEx_p1.load && (idEx_p1.rd != 5'd0) &&
                     ((rs1 == idEx_p1.rd) || (readsRs2 && (rs2 == idEx_p1.rd)));

    // ID/EX register: flush or load-use stall both load a single bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idEx_p1 <= '0;
        end else if (bus.flush_e || loadUse) begin
            idEx_p1 <= '0;
        end else begin
            idEx_p1 <= dec;
        end
    end

    assign bus.load_use_d   = loadUse;
    assign bus.jal_d        = (opcode == OP_JAL);
    assign bus.jalr_d       = (opcode == OP_JALR);
    assign bus.reg_write_e  = idEx_p1.regWrite;
    assign bus.mem_write_e  = idEx_p1.memWrite;
    assign bus.load_e       = idEx_p1.load;
    assign bus.result_src_e = idEx_p1.resultSrc;
    assign bus.alu_ctrl_e   = idEx_p1.aluCtrl;
    assign bus.alu_src_e    = idEx_p1.aluSrc;
    assign bus.branch_e     = idEx_p1.branch;
    assign bus.jal_e        = idEx_p1.jal;
    assign bus.jalr_e       = idEx_p1.jalr;
    assign bus.funct3_e     = idEx_p1.funct3;
    assign bus.rd1_e        = idEx_p1.rd1;
    assign bus.rd2_e        = idEx_p1.rd2;
    assign bus.imm_ext_e    = idEx_p1.immExt;
    assign bus.rs1_e        = idEx_p1.rs1;
    assign bus.rs2_e        = idEx_p1.rs2;
    assign bus.rd_e         = idEx_p1.rd;
    assign bus.pc_e         = idEx_p1.pc;
    assign bus.pc_plus4_e   = idEx_p1.pcPlus4;

endmodule
